// File: rtl/cv32e41s_pkg.sv
// rtl/cv32e41s_pkg.sv - shared types and result-slice helper for the Zbc carry-less multiply sequencer
package cv32e41s_pkg;

    localparam int CLMUL_DATA_W = 32;

    typedef enum logic [1:0] {
        CLMUL_LO  = 2'd0,
        CLMUL_HI  = 2'd1,
        CLMUL_REV = 2'd2
    } clmul_op_e;

    typedef enum logic [1:0] {
        CLMUL_IDLE = 2'd0,
        CLMUL_BUSY = 2'd1,
        CLMUL_DONE = 2'd2
    } clmul_state_e;

    // Picks the 32-bit window of the 64-bit carry-less product for each op
    function automatic logic [CLMUL_DATA_W-1:0] clmul_select(
        input logic [2*CLMUL_DATA_W-1:0] acc,
        input clmul_op_e                 op
    );
        logic [CLMUL_DATA_W-1:0] res;
        case (op)
            CLMUL_HI:  res = acc[63:32];
            CLMUL_REV: res = acc[62:31];
            default:   res = acc[31:0];
        endcase
        return res;
    endfunction

endpackage

// File: rtl/cv32e41s_clmul_step.sv
// rtl/cv32e41s_clmul_step.sv - combinational partial carry-less product for one slice of the multiplier
module cv32e41s_clmul_step
    import cv32e41s_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 4
) (
    input  logic [2*CLMUL_DATA_W-1:0] mcand,
    input  logic [BITS_PER_CYCLE-1:0] mplier_bits,
    output logic [2*CLMUL_DATA_W-1:0] delta
);

    always_comb begin
        delta = '0;
        for (int j = 0; j < BITS_PER_CYCLE; j++) begin
            if (mplier_bits[j]) begin
                delta = delta ^ (mcand << j);
            end
        end
    end

endmodule

// File: rtl/cv32e41s_b_clmul_seq.sv
// rtl/cv32e41s_b_clmul_seq.sv - multi-cycle clmul/clmulh/clmulr sequencer; CV32E41S_CLMUL_EARLY_TERM_EN enables data-dependent early finish
module cv32e41s_b_clmul_seq
    import cv32e41s_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_i,
    output logic                    ready_o,
    input  logic [1:0]              op_i,
    input  logic [CLMUL_DATA_W-1:0] rs1_i,
    input  logic [CLMUL_DATA_W-1:0] rs2_i,
    input  logic                    kill_i,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic [CLMUL_DATA_W-1:0] result_o,
    output logic                    busy_o
);

    localparam int STEPS = CLMUL_DATA_W / BITS_PER_CYCLE;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEPS - 1);

    if (!(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 || BITS_PER_CYCLE == 4 ||
          BITS_PER_CYCLE == 8 || BITS_PER_CYCLE == 16 || BITS_PER_CYCLE == 32)) begin : g_bad_bpc
        $error("cv32e41s_b_clmul_seq: BITS_PER_CYCLE must be 1, 2, 4, 8, 16 or 32");
    end

    clmul_state_e              state_q, state_d;
    clmul_op_e                 op_q;
    logic [2*CLMUL_DATA_W-1:0] acc_q;
    logic [2*CLMUL_DATA_W-1:0] mcand_q;
    logic [CLMUL_DATA_W-1:0]   mplier_q;
    logic [CLMUL_DATA_W-1:0]   mplier_nxt;
    logic [CNT_W-1:0]          cnt_q;
    logic [2*CLMUL_DATA_W-1:0] delta;
    logic                      accept;
    logic                      last_step;

    cv32e41s_clmul_step #(
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_step (
        .mcand       (mcand_q),
        .mplier_bits (mplier_q[BITS_PER_CYCLE-1:0]),
        .delta       (delta)
    );

    assign mplier_nxt = mplier_q >> BITS_PER_CYCLE;

`ifdef CV32E41S_CLMUL_EARLY_TERM_EN
    // Once no multiplier bits remain, further steps cannot change acc
    assign last_step = (cnt_q == CNT_LAST) || (mplier_nxt == '0);
`else
    assign last_step = (cnt_q == CNT_LAST);
`endif

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        ready_o  = (state_q == CLMUL_IDLE);
        valid_o  = (state_q == CLMUL_DONE);
        busy_o   = (state_q != CLMUL_IDLE);
        result_o = (state_q == CLMUL_DONE) ? clmul_select(acc_q, op_q) : '0;
        if (kill_i) begin
            state_d = CLMUL_IDLE;
        end else begin
            case (state_q)
                CLMUL_IDLE: begin
                    if (valid_i) begin
                        accept  = 1'b1;
                        state_d = CLMUL_BUSY;
                    end
                end
                CLMUL_BUSY: begin
                    if (last_step) begin
                        state_d = CLMUL_DONE;
                    end
                end
                CLMUL_DONE: begin
                    if (ready_i) begin
                        state_d = CLMUL_IDLE;
                    end
                end
                default: state_d = CLMUL_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= CLMUL_IDLE;
            op_q     <= CLMUL_LO;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q <= state_d;
            if (kill_i) begin
                acc_q <= '0;
                cnt_q <= '0;
            end else if (accept) begin
                // The reserved encoding falls back to the low-half product
                op_q     <= (op_i == 2'd3) ? CLMUL_LO : clmul_op_e'(op_i);
                mcand_q  <= {{CLMUL_DATA_W{1'b0}}, rs1_i};
                mplier_q <= rs2_i;
                acc_q    <= '0;
                cnt_q    <= '0;
            end else if (state_q == CLMUL_BUSY) begin
                acc_q    <= acc_q ^ delta;
                mcand_q  <= mcand_q << BITS_PER_CYCLE;
                mplier_q <= mplier_nxt;
                cnt_q    <= cnt_q + CNT_W'(1);
            end
        end
    end

    a_op_legal: assert property (@(posedge clk) disable iff (rst)
        (valid_i && ready_o && !kill_i) |-> (op_i != 2'd3));

endmodule

// File: tb/tb_cv32e41s_b_clmul_seq.sv
// tb/tb_cv32e41s_b_clmul_seq.sv - scoreboard bench for the carry-less multiply sequencer
module tb_cv32e41s_b_clmul_seq;

    localparam int BPC = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_i = 1'b0;
    logic        kill_i = 1'b0;
    logic        ready_i = 1'b0;
    logic [1:0]  op_i = 2'd0;
    logic [31:0] rs1_i = '0;
    logic [31:0] rs2_i = '0;
    logic        ready_o;
    logic        valid_o;
    logic        busy_o;
    logic [31:0] result_o;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    cv32e41s_b_clmul_seq #(
        .BITS_PER_CYCLE (BPC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .op_i     (op_i),
        .rs1_i    (rs1_i),
        .rs2_i    (rs2_i),
        .kill_i   (kill_i),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .result_o (result_o),
        .busy_o   (busy_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_clmul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = '0;
        for (int i = 0; i < 32; i++)
            for (int k = 0; k < 32; k++)
                if (a[i] && b[k]) p[i+k] = ~p[i+k];
        case (op)
            2'd1:    return p[63:32];
            2'd2:    return p[62:31];
            default: return p[31:0];
        endcase
    endfunction

    function automatic int exp_latency(input logic [31:0] b);
`ifdef CV32E41S_CLMUL_EARLY_TERM_EN
        int msb;
        msb = -1;
        for (int i = 0; i < 32; i++) if (b[i]) msb = i;
        if (msb < 0) return 1;
        return (msb + BPC) / BPC;
`else
        return 32 / BPC;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int hold);
        int          lat;
        logic [31:0] held;
        check_eq("ready_before", {31'b0, ready_o}, 32'd1);
        valid_i = 1'b1;
        op_i    = op;
        rs1_i   = a;
        rs2_i   = b;
        ready_i = 1'b0;
        exp_q.push_back(exp);
        step();
        valid_i = 1'b0;
        check_eq("busy_after_accept", {31'b0, busy_o}, 32'd1);
        lat = 0;
        while (!valid_o && lat < 200) begin
            step();
            lat++;
        end
        check_eq("latency", 32'(lat), 32'(exp_latency(b)));
        check_eq("ready_in_done", {31'b0, ready_o}, 32'd0);
        held = result_o;
        for (int h = 0; h < hold; h++) begin
            step();
            check_eq("hold_valid", {31'b0, valid_o}, 32'd1);
            check_eq("hold_ready", {31'b0, ready_o}, 32'd0);
            check_eq("hold_result", result_o, held);
        end
        ready_i = 1'b1;
        if (exp_q.size() > 0) check_eq("result", result_o, exp_q.pop_front());
        step();
        ready_i = 1'b0;
        check_eq("idle_after", {29'b0, valid_o, ready_o, busy_o}, 32'b010);
    endtask

    initial begin
        logic        seen;
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        step();
        step();
        check_eq("reset_outputs", {29'b0, valid_o, ready_o, busy_o}, 32'b010);
        check_eq("reset_result", result_o, 32'h0);
        rst = 1'b0;
        step();

        run_op(2'd0, 32'h3, 32'h3, 32'h0000_0005, 0);
        run_op(2'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0);
        run_op(2'd2, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 0);
        run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h5555_5555, 0);
        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h5555_5555, 5);
        run_op(2'd0, 32'h1234_5678, 32'h1, 32'h1234_5678, 1);
        run_op(2'd2, 32'hDEAD_BEEF, 32'h0, 32'h0, 0);

        valid_i = 1'b1;
        kill_i  = 1'b1;
        op_i    = 2'd0;
        rs1_i   = 32'h3;
        rs2_i   = 32'h3;
        step();
        valid_i = 1'b0;
        kill_i  = 1'b0;
        check_eq("kill_blocks_accept", {29'b0, valid_o, ready_o, busy_o}, 32'b010);

        valid_i = 1'b1;
        rs2_i   = 32'hF000_0003;
        step();
        valid_i = 1'b0;
        step();
        step();
        kill_i = 1'b1;
        step();
        kill_i = 1'b0;
        check_eq("kill_to_idle", {29'b0, valid_o, ready_o, busy_o}, 32'b010);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (valid_o) seen = 1'b1;
        end
        check_eq("killed_no_result", {31'b0, seen}, 32'd0);
        run_op(2'd0, 32'h3, 32'h3, 32'h5, 0);

        valid_i = 1'b1;
        op_i    = 2'd1;
        rs1_i   = 32'hFFFF_FFFF;
        rs2_i   = 32'hFFFF_FFFF;
        step();
        valid_i = 1'b0;
        step();
        step();
        step();
        rst = 1'b1;
        #1;
        check_eq("rst_mid_outputs", {29'b0, valid_o, ready_o, busy_o}, 32'b010);
        check_eq("rst_mid_result", result_o, 32'h0);
        step();
        rst = 1'b0;
        step();
        run_op(2'd2, 32'hA5A5_0F0F, 32'h0123_4567, ref_clmul(2'd2, 32'hA5A5_0F0F, 32'h0123_4567), 0);

        for (int n = 0; n < 36; n++) begin
            rop = 2'(n % 3);
            ra  = $urandom;
            rb  = $urandom;
            if (n % 4 == 3) rb = rb >> $urandom_range(0, 31);
            run_op(rop, ra, rb, ref_clmul(rop, ra, rb), $urandom_range(0, 2));
        end

        check_eq("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
